// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. Every operation
//   takes XLEN+1 cycles from accept to the done pulse, with no early-out.
//   Multiplies use radix-2 shift-add. Divides use restoring division, one
//   quotient bit per cycle. Operands are reduced to magnitudes on capture.
//   The result sign is applied once, on the final CALC->DONE edge.
//
// Configuration macro:
//   MULDIV_DIV_EN  defined   : DIV/DIVU/REM/REMU are implemented.
//                  undefined : the divider is removed. Ops 4..7 still run for
//                              XLEN+1 cycles, then complete with result 0.
//
// Ports:
//   clk_i     rising-edge clock
//   rst_i     synchronous active-high reset
//   start_i   request; accepted only while busy_o is low
//   flush_i   abort any in-flight operation (no done, result kept)
//   op_i      RV32M funct3 (0 MUL .. 7 REMU)
//   a_i, b_i  rs1/rs2 operands, sampled on accept
//   busy_o    operation in progress
//   done_o    one-cycle pulse when result_o becomes valid
//   result_o  last completed result, held until the next completion
// -----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            flush_i,
   input  logic [2:0]      op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   localparam int CW = $clog2(XLEN) + 1;
   localparam int AW = 2 * XLEN;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // Two's-complement negation at XLEN bits.
   function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
      return ~v + {{(XLEN-1){1'b0}}, 1'b1};
   endfunction

   // Two's-complement negation at 2*XLEN bits.
   function automatic logic [AW-1:0] neg_2x(input logic [AW-1:0] v);
      return ~v + {{(AW-1){1'b0}}, 1'b1};
   endfunction

   // Absolute value when the operand is treated as signed, else pass-through.
   // The most negative value maps to 2^(XLEN-1), which is still exact unsigned.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                 input logic            is_signed);
      logic [XLEN-1:0] m;
      if (is_signed && v[XLEN-1]) begin
         m = neg_x(v);
      end else begin
         m = v;
      end
      return m;
   endfunction

   // Registers and their next-state values.
   state_e            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand (mul) or divisor (div)
   logic [AW-1:0]     acc_q, acc_d;       // {hi, lo}: product or {remainder, quotient}
   logic              neg_q, neg_d;       // negate the final result
   logic [XLEN-1:0]   result_q, result_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Capture-side decode.
   logic              a_signed_s;
   logic              b_signed_s;
   logic              res_neg_s;
   logic [XLEN-1:0]   mag_a_s;
   logic [XLEN-1:0]   mag_b_s;
   logic [XLEN-1:0]   cap_opnd_s;
   logic [AW-1:0]     cap_acc_s;

   // Datapath step and final value.
   logic [XLEN:0]     mul_sum_s;
   logic [AW-1:0]     mul_next_s;
   logic [AW-1:0]     step_s;
   logic [AW-1:0]     prod_s;
   logic [XLEN-1:0]   fin_s;
`ifdef MULDIV_DIV_EN
   logic [XLEN:0]     div_part_s;
   logic [XLEN:0]     div_diff_s;
   logic [XLEN-1:0]   div_rem_s;
   logic [AW-1:0]     div_next_s;
   logic [XLEN-1:0]   quo_s;
   logic [XLEN-1:0]   rem_s;
`endif

   // Decode operand signedness and the result sign from the incoming op.
   always_comb begin
      a_signed_s = 1'b0;
      b_signed_s = 1'b0;
      res_neg_s  = 1'b0;
      case (op_i)
         OP_MUL: begin
            // Low half of the product is the same for signed and unsigned.
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
            res_neg_s  = 1'b0;
         end
         OP_MULH: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
            res_neg_s  = a_i[XLEN-1] ^ b_i[XLEN-1];
         end
         OP_MULHSU: begin
            a_signed_s = 1'b1;
            b_signed_s = 1'b0;
            res_neg_s  = a_i[XLEN-1];
         end
         OP_MULHU: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
            res_neg_s  = 1'b0;
         end
`ifdef MULDIV_DIV_EN
         OP_DIV: begin
            // Divide by zero must give an all-ones quotient, so no negation.
            // Signed overflow (-2^(XLEN-1) / -1) needs no special case: the
            // magnitude quotient is 2^(XLEN-1) with positive sign, which is a_i.
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
            res_neg_s  = (b_i != {XLEN{1'b0}}) & (a_i[XLEN-1] ^ b_i[XLEN-1]);
         end
         OP_DIVU: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
            res_neg_s  = 1'b0;
         end
         OP_REM: begin
            // Remainder takes the dividend sign; for b=0 this rebuilds a_i.
            a_signed_s = 1'b1;
            b_signed_s = 1'b1;
            res_neg_s  = a_i[XLEN-1];
         end
         OP_REMU: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
            res_neg_s  = 1'b0;
         end
`endif
         default: begin
            a_signed_s = 1'b0;
            b_signed_s = 1'b0;
            res_neg_s  = 1'b0;
         end
      endcase
   end

   // Build the operand/accumulator load values for an accepted request.
   always_comb begin
      mag_a_s = magnitude(a_i, a_signed_s);
      mag_b_s = magnitude(b_i, b_signed_s);
      if (op_i[2]) begin
`ifdef MULDIV_DIV_EN
         // Divide: divisor held aside, dividend shifts out of the low half.
         cap_opnd_s = mag_b_s;
         cap_acc_s  = {{XLEN{1'b0}}, mag_a_s};
`else
         cap_opnd_s = {XLEN{1'b0}};
         cap_acc_s  = {AW{1'b0}};
`endif
      end else begin
         // Multiply: multiplicand held aside, multiplier in the low half.
         cap_opnd_s = mag_a_s;
         cap_acc_s  = {{XLEN{1'b0}}, mag_b_s};
      end
   end

   // One shift-add multiply step; the carry out of the add enters the top bit.
   always_comb begin
      if (acc_q[0]) begin
         mul_sum_s = {1'b0, acc_q[AW-1:XLEN]} + {1'b0, opnd_q};
      end else begin
         mul_sum_s = {1'b0, acc_q[AW-1:XLEN]};
      end
      mul_next_s = {mul_sum_s, acc_q[XLEN-1:1]};
   end

`ifdef MULDIV_DIV_EN
   // One restoring-divide step. The partial remainder is XLEN+1 bits wide so
   // divisors with the top bit set cannot lose the shifted-in bit.
   always_comb begin
      div_part_s = acc_q[AW-1:XLEN-1];
      div_diff_s = div_part_s - {1'b0, opnd_q};
      if (div_diff_s[XLEN]) begin
         div_rem_s = div_part_s[XLEN-1:0];
      end else begin
         div_rem_s = div_diff_s[XLEN-1:0];
      end
      div_next_s = {div_rem_s, acc_q[XLEN-2:0], ~div_diff_s[XLEN]};
   end
`endif

   // Select the step for the running op and form the signed final value.
   always_comb begin
`ifdef MULDIV_DIV_EN
      if (op_q[2]) begin
         step_s = div_next_s;
      end else begin
         step_s = mul_next_s;
      end
      quo_s = neg_q ? neg_x(div_next_s[XLEN-1:0]) : div_next_s[XLEN-1:0];
      rem_s = neg_q ? neg_x(div_next_s[AW-1:XLEN]) : div_next_s[AW-1:XLEN];
`else
      step_s = mul_next_s;
`endif
      prod_s = neg_q ? neg_2x(mul_next_s) : mul_next_s;
      case (op_q)
         OP_MUL:    fin_s = prod_s[XLEN-1:0];
         OP_MULH:   fin_s = prod_s[AW-1:XLEN];
         OP_MULHSU: fin_s = prod_s[AW-1:XLEN];
         OP_MULHU:  fin_s = prod_s[AW-1:XLEN];
`ifdef MULDIV_DIV_EN
         OP_DIV:    fin_s = quo_s;
         OP_DIVU:   fin_s = quo_s;
         OP_REM:    fin_s = rem_s;
         OP_REMU:   fin_s = rem_s;
`endif
         default:   fin_s = {XLEN{1'b0}};
      endcase
   end

   // Control FSM: next state, operand capture, iteration and completion.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      result_d = result_q;
      if (flush_i) begin
         // Abort wins over any start in the same cycle; result is untouched.
         state_d = S_IDLE;
         cnt_d   = {CW{1'b0}};
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (start_i) begin
                  state_d = S_CALC;
                  cnt_d   = CW'(XLEN);
                  op_d    = op_i;
                  opnd_d  = cap_opnd_s;
                  acc_d   = cap_acc_s;
                  neg_d   = res_neg_s;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CALC: begin
               acc_d = step_s;
               if (cnt_q == CW'(1)) begin
                  state_d  = S_DONE;
                  cnt_d    = {CW{1'b0}};
                  result_d = fin_s;
               end else begin
                  cnt_d = cnt_q - CW'(1);
               end
            end
            default: begin
               state_d = S_IDLE;
               cnt_d   = {CW{1'b0}};
            end
         endcase
      end
      busy_d = (state_d == S_CALC);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         cnt_q    <= {CW{1'b0}};
         op_q     <= 3'd0;
         opnd_q   <= {XLEN{1'b0}};
         acc_q    <= {AW{1'b0}};
         neg_q    <= 1'b0;
         result_q <= {XLEN{1'b0}};
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (XLEN=32). Expected results come from a
//   plain-arithmetic RV32M model; divide ops expect 0 when MULDIV_DIV_EN is
//   not defined.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

   localparam int XLEN = 32;
`ifdef MULDIV_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif
   localparam int LAT = XLEN + 1;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  op = 3'd0;
   logic [31:0] a = 32'd0;
   logic [31:0] b = 32'd0;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk_i    (clk),
      .rst_i    (rst),
      .start_i  (start),
      .flush_i  (flush),
      .op_i     (op),
      .a_i      (a),
      .b_i      (b),
      .busy_o   (busy),
      .done_o   (done),
      .result_o (result)
   );

   // RV32M reference computed with 64-bit integer arithmetic.
   function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                         input logic [31:0] y);
      logic signed [63:0] sp;
      logic [63:0]        up;
      logic               ovf;
      ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
      if (o[2] && !DIV_EN) return 32'd0;
      case (o)
         3'd0: begin up = {32'd0, x} * {32'd0, y}; return up[31:0]; end
         3'd1: begin sp = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}); return sp[63:32]; end
         3'd2: begin sp = $signed({{32{x[31]}}, x}) * $signed({32'd0, y}); return sp[63:32]; end
         3'd3: begin up = {32'd0, x} * {32'd0, y}; return up[63:32]; end
         3'd4: begin
            if (y == 32'd0) return 32'hFFFF_FFFF;
            if (ovf) return x;
            return $signed(x) / $signed(y);
         end
         3'd5: begin
            if (y == 32'd0) return 32'hFFFF_FFFF;
            return x / y;
         end
         3'd6: begin
            if (y == 32'd0) return x;
            if (ovf) return 32'd0;
            return $signed(x) % $signed(y);
         end
         default: begin
            if (y == 32'd0) return x;
            return x % y;
         end
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   // Issue one op (from a negedge) and wait for done. lat counts negedges after
   // the accept edge (0 on timeout); busy_ok is cleared if busy drops early or
   // is still high in the done cycle.
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output int lat, output bit busy_ok);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; busy_ok = 1'b1; r = 32'd0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin
            lat = k; r = result;
            if (busy) busy_ok = 1'b0;
            break;
         end else if (!busy) begin
            busy_ok = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
      checks++; if (result !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", result); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   logic [2:0]  d_op  [13] = '{3'd0, 3'd3, 3'd1, 3'd1, 3'd2, 3'd5, 3'd7, 3'd4, 3'd6,
                               3'd4, 3'd6, 3'd4, 3'd6};
   logic [31:0] d_a   [13] = '{32'd7, 32'd7, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'd100,
                               32'd100, 32'hFFFF_FF9C, 32'hFFFF_FF9C, 32'd5, 32'd5,
                               32'h8000_0000, 32'h8000_0000};
   logic [31:0] d_b   [13] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000,
                               32'hFFFF_FFFF, 32'd7, 32'd7, 32'd7, 32'd7, 32'd0, 32'd0,
                               32'hFFFF_FFFF, 32'hFFFF_FFFF};
   logic [31:0] d_exp [13] = '{32'hFFFF_FFEB, 32'h0000_0006, 32'hFFFF_FFFF, 32'h4000_0000,
                               32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFF2, 32'hFFFF_FFFE,
                               32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};

   task automatic test_directed();
      logic [31:0] r, exp;
      int          lat;
      bit          bok;
      logic [2:0]  o;
      for (int i = 0; i < 13; i++) begin
         o = d_op[i];
         exp = (o[2] && !DIV_EN) ? 32'd0 : d_exp[i];
         run_op(o, d_a[i], d_b[i], r, lat, bok);
         checks++; if (r !== exp) begin failures++; $display("FAIL directed_result[%0d] op=%0d: got %h expected %h", i, o, r, exp); end
         checks++; if (lat !== LAT) begin failures++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
         checks++; if (!bok) begin failures++; $display("FAIL directed_busy[%0d]: got busy pattern wrong expected high through CALC", i); end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] x1, y1, x2, y2, r1, r2, e2;
      logic [2:0]  o1, o2;
      int          l1, l2;
      bit          k1, k2;
      o1 = 3'($urandom_range(0, 7)); x1 = $urandom; y1 = $urandom;
      o2 = 3'($urandom_range(0, 7)); x2 = $urandom; y2 = $urandom;
      e2 = model(o2, x2, y2);
      run_op(o1, x1, y1, r1, l1, k1);
      run_op(o2, x2, y2, r2, l2, k2);   // started in the done cycle of the first
      checks++; if (r1 !== model(o1, x1, y1)) begin failures++; $display("FAIL b2b_first_result: got %h expected %h", r1, model(o1, x1, y1)); end
      checks++; if (l2 !== LAT) begin failures++; $display("FAIL b2b_second_latency: got %0d expected %0d", l2, LAT); end
      checks++; if (r2 !== e2) begin failures++; $display("FAIL b2b_second_result: got %h expected %h", r2, e2); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_one_cycle: got %b expected 0", done); end
      checks++; if (result !== e2) begin failures++; $display("FAIL result_held: got %h expected %h", result, e2); end
   endtask

   task automatic test_start_ignored();
      logic [31:0] prev, r;
      int          lat;
      bit          held_ok;
      prev = result;
      op = 3'd0; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      lat = 0; held_ok = 1'b1; r = 32'd0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin lat = k; r = result; break; end
         if (result !== prev) held_ok = 1'b0;
         if (k >= 2 && k <= 19) begin
            start = 1'b1; op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      checks++; if (r !== 32'hFFFF_FFEB) begin failures++; $display("FAIL ignored_start_result: got %h expected ffffffeb", r); end
      checks++; if (lat !== LAT) begin failures++; $display("FAIL ignored_start_latency: got %0d expected %0d", lat, LAT); end
      checks++; if (!held_ok) begin failures++; $display("FAIL result_stable_in_calc: got change expected %h held", prev); end
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ignored_start_no_requeue: got busy=%b expected 0", busy); end
   endtask

   task automatic test_flush();
      logic [31:0] prev;
      bit          seen;
      prev = result;
      op = 3'd3; a = $urandom; b = $urandom; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (9) @(negedge clk);
      flush = 1'b1;                      // sampled at CALC edge 10
      @(negedge clk);
      flush = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_busy: got %b expected 0", busy); end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
      checks++; if (seen) begin failures++; $display("FAIL flush_no_done: got done expected none"); end
      checks++; if (result !== prev) begin failures++; $display("FAIL flush_result_kept: got %h expected %h", result, prev); end
      // start together with flush while idle is dropped
      op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_drops_start: got busy=%b expected 0", busy); end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
      checks++; if (seen || result !== prev) begin failures++; $display("FAIL flush_start_no_op: got done=%b result=%h expected none/%h", seen, result, prev); end
   endtask

   task automatic test_reset_mid();
      bit seen;
      op = 3'd1; a = $urandom; b = $urandom; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b1;                        // sampled at CALC edge 15
      @(negedge clk);
      rst = 1'b0;
      checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL midreset_flags: got busy=%b done=%b expected 0/0", busy, done); end
      checks++; if (result !== 32'd0) begin failures++; $display("FAIL midreset_result: got %h expected 0", result); end
      seen = 1'b0;
      repeat (40) begin @(negedge clk); if (done) seen = 1'b1; end
      checks++; if (seen) begin failures++; $display("FAIL midreset_no_done: got done expected none"); end
   endtask

   task automatic test_random();
      logic [31:0] x, y, r, exp;
      logic [2:0]  o;
      int          lat;
      bit          bok;
      for (int i = 0; i < 40; i++) begin
         o = 3'($urandom_range(0, 7)); x = pick(); y = pick();
         exp = model(o, x, y);
         run_op(o, x, y, r, lat, bok);
         checks++; if (r !== exp) begin failures++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h: got %h expected %h", i, o, x, y, r, exp); end
         checks++; if (lat !== LAT) begin failures++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
         checks++; if (!bok) begin failures++; $display("FAIL random_busy[%0d]: got busy pattern wrong expected high through CALC", i); end
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_start_ignored();
      test_flush();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
